// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle MIPS sequencer (master) and the datapath (slave).
// Carries illegal_op only when ILLEGAL_TRAP_EN is defined.
interface multicycle_ctrl_if #(
  parameter int OPCODE_W = 6,
  parameter int STATE_W  = 4
);
  logic [OPCODE_W-1:0] opcode;
  logic                mem_ready;
  logic                pc_write;
  logic                pc_write_cond;
  logic                i_or_d;
  logic                mem_read;
  logic                mem_write;
  logic                ir_write;
  logic                mem_2_reg;
  logic                reg_dst;
  logic                reg_write;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic [1:0]          alu_op;
  logic [1:0]          pc_source;
  logic                instr_done;
  logic [STATE_W-1:0]  state;
`ifdef ILLEGAL_TRAP_EN
  logic                illegal_op;
`endif

  // Memory handshake: mem_read/mem_write stay asserted every cycle of an access;
  // the access completes in the cycle where mem_ready is high alongside the request.
  modport master (
    input  opcode, mem_ready,
`ifdef ILLEGAL_TRAP_EN
    output illegal_op,
`endif
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_2_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, instr_done, state
  );

  modport slave (
    output opcode, mem_ready,
`ifdef ILLEGAL_TRAP_EN
    input  illegal_op,
`endif
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_2_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, instr_done, state
  );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle MIPS control sequencer (R-type, addi, beq, j, lw, sw) with memory-ready stalls.
// Optional ILLEGAL_TRAP_EN: unknown opcodes lock into TRAP instead of executing as NOP.
module multicycle_ctrl_fsm #(
  parameter int OPCODE_W = 6,
  parameter int STATE_W  = 4
) (
  input logic clk,
  input logic rst,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [STATE_W-1:0] {
    FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR,
    R_EXEC, R_WB, ADDI_EXEC, ADDI_WB, BRANCH, JUMP
`ifdef ILLEGAL_TRAP_EN
    , TRAP
`endif
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(8'h00);
  localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(8'h02);
  localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(8'h04);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(8'h08);
  localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(8'h23);
  localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(8'h2B);

  // Moore part of the strobes, registered from the next state. fetch/decode/jump
  // are flags combined with live inputs for the Mealy strobes below.
  typedef struct packed {
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_2_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       done;
    logic       jump;
    logic       fetch;
    logic       decode;
    logic       illegal;
  } ctrl_t;

  state_t state;
  state_t state_nxt;
  ctrl_t  ctrl;

  function automatic logic is_legal(input logic [OPCODE_W-1:0] op);
    return (op == OP_R) || (op == OP_J) || (op == OP_BEQ) || (op == OP_ADDI) ||
           (op == OP_LW) || (op == OP_SW);
  endfunction

  function automatic state_t next_of(input state_t s, input logic [OPCODE_W-1:0] op,
                                     input logic rdy);
    state_t n;
    n = FETCH;
    case (s)
      FETCH:     n = rdy ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_R:         n = R_EXEC;
          OP_ADDI:      n = ADDI_EXEC;
          OP_BEQ:       n = BRANCH;
          OP_J:         n = JUMP;
          OP_LW, OP_SW: n = MEM_ADDR;
`ifdef ILLEGAL_TRAP_EN
          default:      n = TRAP;
`else
          default:      n = FETCH;
`endif
        endcase
      end
      MEM_ADDR:  n = (op == OP_SW) ? MEM_WR : MEM_RD;
      MEM_RD:    n = rdy ? MEM_WB : MEM_RD;
      MEM_WR:    n = rdy ? FETCH : MEM_WR;
      R_EXEC:    n = R_WB;
      ADDI_EXEC: n = ADDI_WB;
`ifdef ILLEGAL_TRAP_EN
      TRAP:      n = TRAP;
`endif
      default:   n = FETCH;
    endcase
    return n;
  endfunction

  function automatic ctrl_t ctrl_of(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
        c.fetch     = 1'b1;
      end
      DECODE: begin
        c.alu_src_b = 2'b11;
        c.decode    = 1'b1;
      end
      MEM_ADDR, ADDI_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      MEM_RD: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      MEM_WB: begin
        c.reg_write = 1'b1;
        c.mem_2_reg = 1'b1;
        c.done      = 1'b1;
      end
      MEM_WR: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      R_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'd2;
      end
      R_WB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
        c.done      = 1'b1;
      end
      ADDI_WB: begin
        c.reg_write = 1'b1;
        c.done      = 1'b1;
      end
      BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 2'd1;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
        c.done          = 1'b1;
      end
      JUMP: begin
        c.jump      = 1'b1;
        c.pc_source = 2'b10;
        c.done      = 1'b1;
      end
`ifdef ILLEGAL_TRAP_EN
      TRAP:    c.illegal = 1'b1;
`endif
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_nxt = next_of(state, bus.opcode, bus.mem_ready);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
      ctrl  <= ctrl_of(FETCH);
    end else begin
      state <= state_nxt;
      ctrl  <= ctrl_of(state_nxt);
    end
  end

  logic fetch_done;
  logic nop_done;
  assign fetch_done = ctrl.fetch & bus.mem_ready & ~rst;
`ifdef ILLEGAL_TRAP_EN
  assign nop_done   = 1'b0;
  assign bus.illegal_op = ctrl.illegal;
`else
  // Unknown opcodes retire in DECODE itself; opcode is only trusted from DECODE on.
  assign nop_done   = ctrl.decode & ~is_legal(bus.opcode) & ~rst;
`endif

  assign bus.pc_write      = ctrl.jump | fetch_done;
  assign bus.ir_write      = fetch_done;
  assign bus.instr_done    = ctrl.done | (ctrl.mem_write & bus.mem_ready & ~rst) | nop_done;
  assign bus.pc_write_cond = ctrl.pc_write_cond;
  assign bus.i_or_d        = ctrl.i_or_d;
  assign bus.mem_read      = ctrl.mem_read;
  assign bus.mem_write     = ctrl.mem_write;
  assign bus.mem_2_reg     = ctrl.mem_2_reg;
  assign bus.reg_dst       = ctrl.reg_dst;
  assign bus.reg_write     = ctrl.reg_write;
  assign bus.alu_src_a     = ctrl.alu_src_a;
  assign bus.alu_src_b     = ctrl.alu_src_b;
  assign bus.alu_op        = ctrl.alu_op;
  assign bus.pc_source     = ctrl.pc_source;
  assign bus.state         = state;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed scoreboard bench for multicycle_ctrl_fsm: each driven cycle pushes the
// hand-derived strobe vector; a negedge monitor pops and compares.
module tb_multicycle_ctrl_fsm;
  localparam int W = 22;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEM_ADDR = 4'd2,
                         S_MEM_RD = 4'd3, S_MEM_WB = 4'd4, S_MEM_WR = 4'd5,
                         S_R_EXEC = 4'd6, S_R_WB = 4'd7, S_ADDI_EXEC = 4'd8,
                         S_ADDI_WB = 4'd9, S_BRANCH = 4'd10, S_JUMP = 4'd11,
                         S_TRAP = 4'd12;

  logic clk;
  logic rst;
  multicycle_ctrl_if #(.OPCODE_W(6), .STATE_W(4)) bus ();

  multicycle_ctrl_fsm #(.OPCODE_W(6), .STATE_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // clock/reset block: negedge at 5, posedge at 10, so inputs set at posedge+1 are
  // checked at the following negedge
  initial clk = 1'b1;
  always #5 clk = ~clk;

  logic ill;
`ifdef ILLEGAL_TRAP_EN
  assign ill = bus.illegal_op;
`else
  assign ill = 1'b0;
`endif

  logic [W-1:0] obs;
  assign obs = {ill, bus.state, bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read,
                bus.mem_write, bus.ir_write, bus.mem_2_reg, bus.reg_dst, bus.reg_write,
                bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_source, bus.instr_done};

  // scoreboard
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks = 0;
  int           errors = 0;

  function automatic logic [W-1:0] pk(input logic [3:0] st, input logic pcw, input logic pcwc,
      input logic iord, input logic mr, input logic mw, input logic irw, input logic m2r,
      input logic rd, input logic rw, input logic asa, input logic [1:0] asb,
      input logic [1:0] aop, input logic [1:0] psrc, input logic done, input logic il);
    return {il, st, pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, psrc, done};
  endfunction

  function automatic logic [W-1:0] f_fetch(input logic r);
    return pk(S_FETCH, r, 0, 0, 1, 0, r, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0);
  endfunction
  function automatic logic [W-1:0] f_decode(input logic d);
    return pk(S_DECODE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, d, 0);
  endfunction
  function automatic logic [W-1:0] f_mem_addr();
    return pk(S_MEM_ADDR, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0, 0);
  endfunction
  function automatic logic [W-1:0] f_mem_rd();
    return pk(S_MEM_RD, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
  endfunction
  function automatic logic [W-1:0] f_mem_wb();
    return pk(S_MEM_WB, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 1, 0);
  endfunction
  function automatic logic [W-1:0] f_mem_wr(input logic r);
    return pk(S_MEM_WR, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, r, 0);
  endfunction
  function automatic logic [W-1:0] f_r_exec();
    return pk(S_R_EXEC, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 0, 0);
  endfunction
  function automatic logic [W-1:0] f_r_wb();
    return pk(S_R_WB, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 1, 0);
  endfunction
  function automatic logic [W-1:0] f_addi_exec();
    return pk(S_ADDI_EXEC, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0, 0);
  endfunction
  function automatic logic [W-1:0] f_addi_wb();
    return pk(S_ADDI_WB, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 1, 0);
  endfunction
  function automatic logic [W-1:0] f_branch();
    return pk(S_BRANCH, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 1, 0);
  endfunction
  function automatic logic [W-1:0] f_jump();
    return pk(S_JUMP, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 1, 0);
  endfunction
  function automatic logic [W-1:0] f_trap();
    return pk(S_TRAP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1);
  endfunction

  // driver task: one cycle of inputs plus its expected response
  task automatic step(input logic r, input logic rdy, input logic [5:0] op,
                      input logic [W-1:0] e, input string nm);
    rst           = r;
    bus.mem_ready = rdy;
    bus.opcode    = op;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  // monitor: outputs are meaningful every cycle, so pop whenever something is queued
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [W-1:0] e;
      string        nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL %s: got %h expected %h", nm, obs, e);
      end
    end
  end

  initial begin
    rst           = 1'b1;
    bus.mem_ready = 1'b0;
    bus.opcode    = 6'h00;
    #1;
    step(1, 0, 6'h00, f_fetch(0),     "reset_state");

    // R-type, no stalls; garbage opcode in FETCH/R_EXEC must be ignored
    step(0, 1, 6'h3F, f_fetch(1),     "r_fetch");
    step(0, 1, 6'h00, f_decode(0),    "r_decode");
    step(0, 1, 6'h3F, f_r_exec(),     "r_exec");
    step(0, 1, 6'h3F, f_r_wb(),       "r_wb");

    // lw with two stall cycles in MEM_RD: 7 cycles
    step(0, 1, 6'h23, f_fetch(1),     "lw_fetch");
    step(0, 1, 6'h23, f_decode(0),    "lw_decode");
    step(0, 1, 6'h23, f_mem_addr(),   "lw_addr");
    step(0, 0, 6'h23, f_mem_rd(),     "lw_rd_stall1");
    step(0, 0, 6'h23, f_mem_rd(),     "lw_rd_stall2");
    step(0, 1, 6'h23, f_mem_rd(),     "lw_rd_done");
    step(0, 1, 6'h23, f_mem_wb(),     "lw_wb");

    // beq, 3 cycles
    step(0, 1, 6'h04, f_fetch(1),     "beq_fetch");
    step(0, 1, 6'h04, f_decode(0),    "beq_decode");
    step(0, 1, 6'h04, f_branch(),     "beq_branch");

    // j then sw back-to-back
    step(0, 1, 6'h02, f_fetch(1),     "j_fetch");
    step(0, 1, 6'h02, f_decode(0),    "j_decode");
    step(0, 1, 6'h02, f_jump(),       "j_jump");
    step(0, 1, 6'h2B, f_fetch(1),     "sw_fetch");
    step(0, 1, 6'h2B, f_decode(0),    "sw_decode");
    step(0, 1, 6'h2B, f_mem_addr(),   "sw_addr");
    step(0, 1, 6'h2B, f_mem_wr(1),    "sw_wr");

    // addi with a fetch stall
    step(0, 0, 6'h08, f_fetch(0),     "addi_fetch_stall");
    step(0, 1, 6'h08, f_fetch(1),     "addi_fetch");
    step(0, 1, 6'h08, f_decode(0),    "addi_decode");
    step(0, 1, 6'h08, f_addi_exec(),  "addi_exec");
    step(0, 1, 6'h08, f_addi_wb(),    "addi_wb");

    // reset while MEM_WR is stalled aborts the store
    step(0, 1, 6'h2B, f_fetch(1),     "abort_fetch");
    step(0, 1, 6'h2B, f_decode(0),    "abort_decode");
    step(0, 1, 6'h2B, f_mem_addr(),   "abort_addr");
    step(0, 0, 6'h2B, f_mem_wr(0),    "abort_wr_stall");
    step(1, 0, 6'h2B, f_fetch(0),     "abort_reset");
    step(0, 1, 6'h00, f_fetch(1),     "abort_refetch");
    step(0, 1, 6'h00, f_decode(0),    "abort_decode2");
    step(0, 1, 6'h00, f_r_exec(),     "abort_rexec");
    step(0, 1, 6'h00, f_r_wb(),       "abort_rwb");

    // unknown opcode
    step(0, 1, 6'h3F, f_fetch(1),     "ill_fetch");
`ifdef ILLEGAL_TRAP_EN
    step(0, 1, 6'h3F, f_decode(0),    "ill_decode");
    step(0, 1, 6'h3F, f_trap(),       "trap_1");
    step(0, 1, 6'h00, f_trap(),       "trap_2");
    step(0, 1, 6'h23, f_trap(),       "trap_3");
    step(1, 0, 6'h00, f_fetch(0),     "trap_reset");
`else
    step(0, 1, 6'h3F, f_decode(1),    "nop_decode");
    step(0, 0, 6'h3F, f_fetch(0),     "nop_fetch_after");
`endif
    step(0, 1, 6'h04, f_fetch(1),     "end_fetch");
    step(0, 1, 6'h04, f_decode(0),    "end_decode");
    step(0, 1, 6'h04, f_branch(),     "end_branch");

    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
